key_schedule_iter: RTL and testbench

- Iterative AES key schedule for AES-128, AES-192 and AES-256, selected by parameter. It replaces the single-round `key_expansion` stage.
- Accepts a cipher key over a valid/ready handshake.
- Generates one 32-bit schedule word per cycle.
- Streams round keys 0..Nr as 128-bit blocks to the round datapath, with backpressure.

---
 rtl/key_schedule_iter.sv | 229 ++++++++++++++++++++++
 tb/tb_key_schedule_iter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_iter.sv
// key_schedule_iter: word-serial AES key schedule (AES-128/192/256 via KEY_BITS).
// Produces one 32-bit schedule word per cycle and streams 128-bit round keys
// 0..NR over a valid/ready handshake with backpressure.
// Optional macro KEY_SCHED_DECRYPT_EN: buffers the whole schedule and, when
// i_reverse is set at key accept, emits the round keys NR down to 0.
module key_schedule_iter #(
   parameter int KEY_BITS = 128,
   parameter int NK       = KEY_BITS / 32,
   parameter int NR       = NK + 6
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                i_key_valid,
   output logic                o_key_ready,
   input  logic [KEY_BITS-1:0] i_key,
   input  logic                i_reverse,
   output logic                o_rk_valid,
   input  logic                i_rk_ready,
   output logic [127:0]        o_round_key,
   output logic [3:0]          o_round_idx,
   output logic                o_last
);

   if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256) ||
       NK != KEY_BITS / 32 || NR != NK + 6) begin : g_bad_cfg
      $error("key_schedule_iter: KEY_BITS must be 128, 192 or 256 and NK/NR left derived");
   end

   localparam logic [5:0] LAST_WORD = 6'(4 * (NR + 1) - 1);

   typedef enum logic [1:0] {IDLE, EXPAND, DRAIN} state_t;

   state_t        r_state, w_next;
   logic [31:0]   r_win [NK];
   logic [31:0]   r_asm [3];
   logic [5:0]    r_i;
   logic [2:0]    r_pos;
   logic [7:0]    r_rcon;
   logic          r_key_ready;
   logic          r_rk_valid;
   logic [127:0]  r_rk;
   logic [3:0]    r_idx;
   logic          r_last;

   logic [31:0]   w_word, w_old, w_prev, w_key_word, w_sub_in, w_sub;
   logic          w_accept, w_xfer, w_rk_slot, w_stall, w_adv, w_rev_mode;
   logic          w_load_fwd, w_load, w_load_last;
   logic [127:0]  w_load_key;
   logic [3:0]    w_load_idx;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, t;
      p = '0;
      t = a;
      for (int unsigned k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as x^254 in GF(2^8) followed by the affine map (0 maps to 0x63)
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r, s;
      r = 8'h01;
      s = x;
      for (int unsigned k = 0; k < 7; k++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

`ifdef KEY_SCHED_DECRYPT_EN
   logic [127:0]  r_buf [15];
   logic          r_rev, r_rem;
   logic [3:0]    r_ridx;
   logic          w_load_rev;
   assign w_rev_mode = r_rev;
   assign w_load_rev = (r_state == DRAIN) && r_rev && r_rem && (!r_rk_valid || i_rk_ready);
`else
   logic          w_unused_rev;
   assign w_unused_rev = i_reverse;
   assign w_rev_mode   = 1'b0;
`endif

   assign w_accept  = (r_state == IDLE) && r_key_ready && i_key_valid;
   assign w_xfer    = r_rk_valid && i_rk_ready;
   assign w_rk_slot = (r_i[1:0] == 2'd3);
   assign w_stall   = w_rk_slot && r_rk_valid && !i_rk_ready && !w_rev_mode;
   assign w_adv     = (r_state == EXPAND) && !w_stall;
   assign w_load_fwd = w_adv && w_rk_slot && !w_rev_mode;

   // Next schedule word; window holds w[i-NK] at [0] and w[i-1] at [NK-1]
   always_comb begin
      w_old      = r_win[0];
      w_prev     = r_win[NK-1];
      w_key_word = r_win[0];
      for (int unsigned j = 0; j < NK; j++) begin
         if (r_pos == 3'(j)) w_key_word = r_win[j];
      end
      w_sub_in = (r_pos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
      w_sub    = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                  sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};
      if (r_i < 6'(NK))
         w_word = w_key_word;
      else if (r_pos == 3'd0)
         w_word = w_old ^ w_sub ^ {r_rcon, 24'h0};
      else if (NK == 8 && r_pos == 3'd4)
         w_word = w_old ^ w_sub;
      else
         w_word = w_old ^ w_prev;
   end

   // Output-register load source: assembled forward key or buffered reverse key
   always_comb begin
      w_load      = w_load_fwd;
      w_load_key  = {r_asm[0], r_asm[1], r_asm[2], w_word};
      w_load_idx  = r_i[5:2];
      w_load_last = (r_i == LAST_WORD);
`ifdef KEY_SCHED_DECRYPT_EN
      if (w_load_rev) begin
         w_load      = 1'b1;
         w_load_key  = r_buf[r_ridx];
         w_load_idx  = r_ridx;
         w_load_last = (r_ridx == 4'd0);
      end
`endif
   end

   // FSM next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = EXPAND;
         EXPAND:  if (w_adv && r_i == LAST_WORD) w_next = DRAIN;
         DRAIN:   if (w_xfer && r_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // FSM state register and key-ready flag (low throughout reset)
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_key_ready <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_key_ready <= (w_next == IDLE);
      end
   end

   // Word counter, key window, Rcon and assembly shift register
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_i    <= '0;
         r_pos  <= '0;
         r_rcon <= 8'h01;
         for (int unsigned j = 0; j < NK; j++) r_win[j] <= '0;
         for (int unsigned j = 0; j < 3; j++)  r_asm[j] <= '0;
      end else if (w_accept) begin
         r_i    <= '0;
         r_pos  <= '0;
         r_rcon <= 8'h01;
         for (int unsigned j = 0; j < NK; j++) r_win[j] <= i_key[KEY_BITS-1-32*j -: 32];
      end else if (w_adv) begin
         r_i      <= r_i + 6'd1;
         r_pos    <= (r_pos == 3'(NK - 1)) ? 3'd0 : r_pos + 3'd1;
         r_asm[0] <= r_asm[1];
         r_asm[1] <= r_asm[2];
         r_asm[2] <= w_word;
         if (r_i >= 6'(NK)) begin
            for (int unsigned j = 0; j + 1 < NK; j++) r_win[j] <= r_win[j+1];
            r_win[NK-1] <= w_word;
            if (r_pos == 3'd0) r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
         end
      end
   end

   // Output register: a load may coincide with a transfer (no bubble)
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rk_valid <= 1'b0;
         r_rk       <= '0;
         r_idx      <= '0;
         r_last     <= 1'b0;
      end else if (w_load) begin
         r_rk_valid <= 1'b1;
         r_rk       <= w_load_key;
         r_idx      <= w_load_idx;
         r_last     <= w_load_last;
      end else if (w_xfer) begin
         r_rk_valid <= 1'b0;
      end
   end

`ifdef KEY_SCHED_DECRYPT_EN
   // Reverse-order control: direction latch and downward emission counter
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rev  <= 1'b0;
         r_rem  <= 1'b0;
         r_ridx <= '0;
      end else if (w_accept) begin
         r_rev  <= i_reverse;
         r_rem  <= 1'b0;
      end else if (w_adv && r_i == LAST_WORD && r_rev) begin
         r_rem  <= 1'b1;
         r_ridx <= 4'(NR);
      end else if (w_load_rev) begin
         if (r_ridx == 4'd0) r_rem <= 1'b0;
         else                r_ridx <= r_ridx - 4'd1;
      end
   end

   // Round-key buffer fill while expanding in reverse mode
   always_ff @(posedge clock) begin
      if (w_adv && w_rk_slot && r_rev)
         r_buf[r_i[5:2]] <= {r_asm[0], r_asm[1], r_asm[2], w_word};
   end
`endif

   assign o_key_ready = r_key_ready;
   assign o_rk_valid  = r_rk_valid;
   assign o_round_key = r_rk;
   assign o_round_idx = r_idx;
   assign o_last      = r_last;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed bench for key_schedule_iter: AES-128 streams (two keys), AES-192 and
// AES-256 instances, backpressure, mid-schedule reset and reverse ordering.
module tb_key_schedule_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic          kv128, kr128, rev128, v128, rdy128, last128;
   logic [127:0]  key128, rk128;
   logic [3:0]    idx128;

   logic          kv192, kr192, v192, last192;
   logic [191:0]  key192;
   logic [127:0]  rk192;
   logic [3:0]    idx192;

   logic          kv256, kr256, v256, last256;
   logic [255:0]  key256;
   logic [127:0]  rk256;
   logic [3:0]    idx256;

   int n_chk = 0;
   int n_err = 0;

   logic [127:0] KF [0:10] = '{
      128'h5468617473206D79204B756E67204675, 128'hE232FCF191129188B159E4E6D679A293,
      128'h56082007C71AB18F76435569A03AF7FA, 128'hD2600DE7157ABC686339E901C3031EFB,
      128'hA11202C9B468BEA1D75157A01452495B, 128'hB1293B3305418592D210D232C6429B69,
      128'hBD3DC287B87C47156A6C9527AC2E0E4E, 128'hCC96ED1674EAAA031E863F24B2A8316A,
      128'h8E51EF21FABB4522E43D7A0656954B6C, 128'hBFE2BF904559FAB2A16480B4F7F1CBD8,
      128'h28FDDEF86DA4244ACCC0A4FE3B316F26};

   logic [127:0] FI [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

   logic [127:0] got192 [0:15];
   logic [127:0] got256 [0:15];
   int n192 = 0, n256 = 0, lidx192 = -1, lidx256 = -1;

   key_schedule_iter #(.KEY_BITS(128)) u_dut128 (
      .clock(clk), .reset(rst_n), .i_key_valid(kv128), .o_key_ready(kr128),
      .i_key(key128), .i_reverse(rev128), .o_rk_valid(v128), .i_rk_ready(rdy128),
      .o_round_key(rk128), .o_round_idx(idx128), .o_last(last128));

   key_schedule_iter #(.KEY_BITS(192)) u_dut192 (
      .clock(clk), .reset(rst_n), .i_key_valid(kv192), .o_key_ready(kr192),
      .i_key(key192), .i_reverse(1'b0), .o_rk_valid(v192), .i_rk_ready(1'b1),
      .o_round_key(rk192), .o_round_idx(idx192), .o_last(last192));

   key_schedule_iter #(.KEY_BITS(256)) u_dut256 (
      .clock(clk), .reset(rst_n), .i_key_valid(kv256), .o_key_ready(kr256),
      .i_key(key256), .i_reverse(1'b0), .o_rk_valid(v256), .i_rk_ready(1'b1),
      .o_round_key(rk256), .o_round_idx(idx256), .o_last(last256));

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] exp_key(input int sel, input int k);
      return (sel == 0) ? KF[k] : FI[k];
   endfunction

   // capture the wider-key instances (always ready, so every valid cycle is a transfer)
   always @(negedge clk) begin
      if (rst_n && v192) begin
         got192[idx192] = rk192;
         n192++;
         if (last192) lidx192 = int'(idx192);
      end
      if (rst_n && v256) begin
         got256[idx256] = rk256;
         n256++;
         if (last256) lidx256 = int'(idx256);
      end
   end

   // Run one AES-128 schedule; inputs driven and outputs sampled on negedge.
   task automatic stream128(input string nm, input int sel, input bit rev,
                            input int stall_at, input int rst_at);
      int nk, hold, e_rel, xi;
      bit pend, armed, done, rev_eff;
      logic [127:0] held;
      logic [3:0]   held_idx;
      nk = 0; hold = 0; e_rel = 0; pend = 0; armed = 0; done = 0;
      held = '0; held_idx = '0;
`ifdef KEY_SCHED_DECRYPT_EN
      rev_eff = rev;
`else
      rev_eff = 1'b0;
`endif
      check_val({nm, "_ready_idle"}, 128'(kr128), 128'(1));
      key128 = exp_key(sel, 0);
      rev128 = rev;
      kv128  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      kv128 = 1'b0;
      check_val({nm, "_ready_busy"}, 128'(kr128), 128'(0));
      for (int e = 1; e <= 160 && !done; e++) begin
         @(posedge clk);
         if (armed) begin
            if (nk == 10) done = 1'b1;
            nk++;
            pend  = 1'b0;
            armed = 1'b0;
         end
         @(negedge clk);
         if (done) begin
            check_val({nm, "_ready_end"}, 128'(kr128), 128'(1));
            check_val({nm, "_valid_end"}, 128'(v128), 128'(0));
         end else if (v128) begin
            if (!pend) begin
               pend = 1'b1;
               held = rk128;
               held_idx = idx128;
               xi = rev_eff ? 10 - nk : nk;
               check_val($sformatf("%s_key%0d", nm, xi), rk128, exp_key(sel, xi));
               check_val($sformatf("%s_idx%0d", nm, xi), 128'(idx128), 128'(xi));
               check_val($sformatf("%s_last%0d", nm, xi), 128'(last128), 128'(nk == 10));
               if (nk == 0)
                  check_val({nm, "_first_edge"}, 128'(e), 128'(rev_eff ? 45 : 4));
               if (nk == 10 && stall_at < 0)
                  check_val({nm, "_last_edge"}, 128'(e), 128'(rev_eff ? 55 : 44));
               if (stall_at >= 0 && nk == stall_at + 1)
                  check_val({nm, "_no_bubble"}, 128'(e), 128'(e_rel + 1));
               if (nk == stall_at) hold = 20;
            end else begin
               check_val({nm, "_hold_key"}, rk128, held);
               check_val({nm, "_hold_idx"}, 128'(idx128), 128'(held_idx));
            end
            if (nk == rst_at) begin
               rst_n = 1'b0;
               @(posedge clk);
               @(negedge clk);
               check_val({nm, "_rst_valid"}, 128'(v128), 128'(0));
               check_val({nm, "_rst_key"}, rk128, 128'(0));
               check_val({nm, "_rst_idx"}, 128'(idx128), 128'(0));
               check_val({nm, "_rst_last"}, 128'(last128), 128'(0));
               check_val({nm, "_rst_ready"}, 128'(kr128), 128'(0));
               rst_n = 1'b1;
               @(posedge clk);
               @(negedge clk);
               check_val({nm, "_rel_ready"}, 128'(kr128), 128'(1));
               check_val({nm, "_rel_valid"}, 128'(v128), 128'(0));
               done = 1'b1;
            end else if (hold > 0) begin
               rdy128 = 1'b0;
               key128 = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
               kv128  = 1'b1;
               check_val({nm, "_stall_ready"}, 128'(kr128), 128'(0));
               hold--;
            end else begin
               rdy128 = 1'b1;
               kv128  = 1'b0;
               armed  = 1'b1;
               if (stall_at >= 0 && nk == stall_at) e_rel = e;
            end
         end
      end
      check_val({nm, "_completed"}, 128'(done), 128'(1));
      rdy128 = 1'b1;
      kv128  = 1'b0;
      rev128 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      kv128 = 1'b0; key128 = '0; rev128 = 1'b0; rdy128 = 1'b1;
      kv192 = 1'b0; key192 = '0;
      kv256 = 1'b0; key256 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset_ready", 128'(kr128), 128'(0));
      check_val("reset_valid", 128'(v128), 128'(0));
      check_val("reset_key", rk128, 128'(0));
      check_val("reset_idx", 128'(idx128), 128'(0));
      check_val("reset_last", 128'(last128), 128'(0));
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("release_ready", 128'(kr128), 128'(1));
      check_val("release_ready192", 128'(kr192), 128'(1));

      key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
      kv192  = 1'b1;
      key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      kv256  = 1'b1;
      stream128("kf", 0, 1'b0, -1, -1);
      kv192 = 1'b0;
      kv256 = 1'b0;
      repeat (20) @(negedge clk);
      check_val("a192_count", 128'(n192), 128'(13));
      check_val("a192_last_idx", 128'(lidx192), 128'(12));
      check_val("a192_key0", got192[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
      check_val("a192_key1", got192[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
      check_val("a192_key12", got192[12], 128'he98ba06f448c773c8ecc720401002202);
      check_val("a256_count", 128'(n256), 128'(15));
      check_val("a256_last_idx", 128'(lidx256), 128'(14));
      check_val("a256_key1", got256[1], 128'h1f352c073b6108d72d9810a30914dff4);
      check_val("a256_key3", got256[3], 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
      check_val("a256_key14", got256[14], 128'hfe4890d1e6188d0b046df344706c631e);

      stream128("fips", 1, 1'b0, -1, -1);
      stream128("stall", 0, 1'b0, 3, -1);
      stream128("rstmid", 1, 1'b0, -1, 5);
      stream128("restart", 0, 1'b0, -1, -1);
      stream128("rev", 1, 1'b1, -1, -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
